tc0480scp_rom_fetch: RTL

//   Tile-ROM fetch stage directly upstream of TC0480SCP's BG graphics port.

---
 rtl/tc0480scp_rom_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/tc0480scp_rom_fetch.sv
// Tile-ROM fetch stage for the TC0480SCP BG port: services toggle-handshake 64-bit row
// requests from a direct-mapped line cache and refills misses with a 4-beat x16 SDRAM burst.
module tc0480scp_rom_fetch #(
  parameter logic [25:0] BASE_ADDR = 26'h0,
  parameter int          IDX_BITS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [21:0] rom_address,
  input  logic        rom_req,
  output logic        rom_ack,
  output logic [63:0] rom_data,
  output logic [25:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_gnt,
  input  logic        sdr_valid,
  input  logic [15:0] sdr_data
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 19 - IDX_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, BEAT, DONE} state_t;

  state_t state, state_next;

  logic [18:0]          addr_r;
  logic [1:0]           cnt;
  logic                 flush_seen;
  logic [ENTRIES-1:0]   valid;
  logic [63:0]          line_mem [ENTRIES];
  logic [TAG_W-1:0]     tag_mem  [ENTRIES];

  logic [IDX_BITS-1:0]  idx;
  logic [TAG_W-1:0]     tag;
  logic [25:0]          burst_addr;
  logic                 hit;
  logic                 last_beat;
  logic                 install;
  logic                 unused_low_bits;

  assign unused_low_bits = ^rom_address[2:0];

  assign idx        = addr_r[IDX_BITS-1:0];
  assign tag        = addr_r[18:IDX_BITS];
  assign burst_addr = BASE_ADDR + {4'b0, addr_r, 3'b0};
  // A flush arriving during the lookup must not let a stale line through.
  assign hit        = valid[idx] && (tag_mem[idx] == tag) && !flush;
  assign last_beat  = (state == BEAT) && sdr_valid && (cnt == 2'd3);
  assign install    = last_beat && !flush_seen;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rom_req != rom_ack) state_next = LOOKUP;
      LOOKUP:  state_next = hit ? DONE : ISSUE;
      ISSUE:   if (sdr_gnt) state_next = BEAT;
      BEAT:    if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_ack    <= 1'b0;
      rom_data   <= '0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      valid      <= '0;
      flush_seen <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE:   flush_seen <= 1'b0;
        LOOKUP: begin
          if (hit) begin
            rom_data <= line_mem[idx];
          end else begin
            sdr_addr <= burst_addr;
            sdr_req  <= 1'b1;
          end
        end
        ISSUE: begin
          if (sdr_gnt) begin
            sdr_req <= 1'b0;
            cnt     <= '0;
          end
        end
        BEAT: begin
          if (sdr_valid) begin
            rom_data[{cnt, 4'b0} +: 16] <= sdr_data;
            cnt <= cnt + 2'd1;
          end
        end
        DONE:    rom_ack <= rom_req;
        default: ;
      endcase
      // A fetch overlapping a flush still answers the client but never lands in the cache.
      if (flush && (state == ISSUE || state == BEAT)) flush_seen <= 1'b1;
      if (flush)        valid      <= '0;
      else if (install) valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && rom_req != rom_ack) addr_r <= rom_address[21:3];
    if (last_beat) begin
      line_mem[idx] <= {sdr_data, rom_data[47:0]};
      tag_mem[idx]  <= tag;
    end
  end

endmodule
